// File: rtl/vend_fulfil_ctrl.sv
// Vend fulfilment controller: queues dispense/chg5 requests and sequences the
// product motor and change hopper with per-actuation timeout and sticky fault.
module vend_fulfil_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dispense,
  input  logic             chg5,
  input  logic             motor_done,
  input  logic             hopper_done,
  input  logic             fault_clr,
  output logic             motor_en,
  output logic             hopper_en,
  output logic             busy,
  output logic             fault,
  output logic             ovf,
  output logic [CNT_W-1:0] vend_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, VEND, CHANGE, GAP, FAULT} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nxt;
  logic            mem [DEPTH];
  logic            chg_q;
  logic [TW-1:0]   tmo_cnt;
  logic            pop, push_ok, drop, tmo_hit, vend_done;

  always_comb begin
    pop       = (state == IDLE) && (count != '0);
    push_ok   = dispense && ((count < (AW+1)'(DEPTH)) || pop);
    drop      = dispense && !push_ok;
    tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
    count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop);
    state_nxt = state;
    vend_done = 1'b0;
    case (state)
      IDLE:   if (pop) state_nxt = VEND;
      // done wins over a same-cycle expiry
      VEND: begin
        if (motor_done) begin
          vend_done = 1'b1;
          state_nxt = chg_q ? CHANGE : GAP;
        end else if (tmo_hit) begin
          state_nxt = FAULT;
        end
      end
      CHANGE: begin
        if (hopper_done)  state_nxt = GAP;
        else if (tmo_hit) state_nxt = FAULT;
      end
      GAP:    state_nxt = IDLE;
      FAULT:  if (fault_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tmo_cnt    <= '0;
      motor_en   <= 1'b0;
      hopper_en  <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      ovf        <= 1'b0;
      vend_count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      // Counter restarts whenever an actuation state is entered
      if ((state_nxt == state) && ((state == VEND) || (state == CHANGE)))
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;
      motor_en   <= (state_nxt == VEND);
      hopper_en  <= (state_nxt == CHANGE);
      fault      <= (state_nxt == FAULT);
      busy       <= (state_nxt != IDLE) || (count_nxt != '0);
      if (drop)           ovf <= 1'b1;
      else if (fault_clr) ovf <= 1'b0;
      vend_count <= vend_count + CNT_W'(vend_done);
    end
  end

  // Queue storage and popped change flag are data; pointers handle reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= chg5;
    if (pop)     chg_q       <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_vend_fulfil_ctrl.sv
// Bench for vend_fulfil_ctrl: directed scenarios plus random traffic checked
// every cycle against a queue-based behavioural model.
module tb_vend_fulfil_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dispense = 1'b0, chg5 = 1'b0;
  logic          motor_done = 1'b0, hopper_done = 1'b0, fault_clr = 1'b0;
  logic          motor_en, hopper_en, busy, fault, ovf;
  logic [CW-1:0] vend_count;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  vend_fulfil_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .dispense(dispense), .chg5(chg5),
    .motor_done(motor_done), .hopper_done(hopper_done), .fault_clr(fault_clr),
    .motor_en(motor_en), .hopper_en(hopper_en), .busy(busy), .fault(fault),
    .ovf(ovf), .vend_count(vend_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a queue of pending change flags and the current job
  localparam int J_NONE = 0, J_MOTOR = 1, J_HOP = 2, J_GAP = 3, J_FAULT = 4;
  bit      mq[$];
  int      job = J_NONE;
  int      elapsed = 0;
  bit      cur_chg = 1'b0;
  bit      m_ovf = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  bit      m_pop, m_acc;
  int      m_sz;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      job = J_NONE; elapsed = 0; m_ovf = 1'b0; m_cnt = '0;
    end else begin
      m_sz  = mq.size();
      m_pop = (job == J_NONE) && (m_sz > 0);
      m_acc = dispense && ((m_sz < DEPTH) || m_pop);
      if (dispense && !m_acc) m_ovf = 1'b1;
      else if (fault_clr)     m_ovf = 1'b0;
      case (job)
        J_NONE: if (m_pop) begin cur_chg = mq.pop_front(); job = J_MOTOR; elapsed = 1; end
        J_MOTOR: begin
          if (motor_done) begin m_cnt = m_cnt + 1'b1; job = cur_chg ? J_HOP : J_GAP; elapsed = 1; end
          else if (elapsed == TMO) job = J_FAULT;
          else elapsed++;
        end
        J_HOP: begin
          if (hopper_done) job = J_GAP;
          else if (elapsed == TMO) job = J_FAULT;
          else elapsed++;
        end
        J_GAP:   job = J_NONE;
        default: if (fault_clr) job = J_NONE;
      endcase
      if (m_acc) mq.push_back(chg5);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_motor_en",  32'(motor_en),  32'(job == J_MOTOR));
      chk("m_hopper_en", 32'(hopper_en), 32'(job == J_HOP));
      chk("m_fault",     32'(fault),     32'(job == J_FAULT));
      chk("m_busy",      32'(busy),      32'((job != J_NONE) || (mq.size() != 0)));
      chk("m_ovf",       32'(ovf),       32'(m_ovf));
      chk("m_vend_count", {16'b0, vend_count}, {16'b0, m_cnt});
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_outputs", {26'b0, motor_en, hopper_en, busy, fault, ovf, 1'b0}, 32'd0);
    chk("rst_count", {16'b0, vend_count}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single vend without change: motor_en for 4 cycles
    dispense = 1'b1; chg5 = 1'b0;
    step();
    dispense = 1'b0;
    chk("lat_not_yet", 32'(motor_en), 32'd0);
    step();
    chk("lat_motor_on", 32'(motor_en), 32'd1);
    step(); step(); step();
    chk("motor_held", 32'(motor_en), 32'd1);
    chk("no_hopper", 32'(hopper_en), 32'd0);
    motor_done = 1'b1;
    step();
    motor_done = 1'b0;
    chk("motor_off", 32'(motor_en), 32'd0);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("vend1", {16'b0, vend_count}, 32'd1);
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Vend with change
    dispense = 1'b1; chg5 = 1'b1;
    step();
    dispense = 1'b0; chg5 = 1'b0;
    step(); step();
    motor_done = 1'b1;
    step();
    motor_done = 1'b0;
    chk("chg_hopper_on", 32'(hopper_en), 32'd1);
    chk("chg_motor_off", 32'(motor_en), 32'd0);
    hopper_done = 1'b1;
    step();
    step();
    hopper_done = 1'b0;
    chk("chg_gap", {30'b0, motor_en, hopper_en}, 32'd0);
    chk("vend2", {16'b0, vend_count}, 32'd2);

    // Overflow: six back-to-back pulses, motor never completes
    step();
    for (int i = 0; i < 6; i++) begin
      dispense = 1'b1; chg5 = 1'b1;
      step();
    end
    dispense = 1'b0; chg5 = 1'b0;
    chk("ovf_set", 32'(ovf), 32'd1);
    n = 0;
    while (!fault && n < 20) begin step(); n++; end
    chk("fault_reached", 32'(fault), 32'd1);
    chk("tmo_no_vend", {16'b0, vend_count}, 32'd2);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("fault_cleared", {30'b0, fault, ovf}, 32'd0);
    step();

    // Timeout: motor_en lasts exactly TIMEOUT cycles
    n = motor_en ? 1 : 0;
    while (motor_en && n < 20) begin
      step();
      if (motor_en) n++;
    end
    chk("tmo_len", n, TMO);
    chk("tmo_fault", 32'(fault), 32'd1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    step();
    chk("next_req", 32'(motor_en), 32'd1);
    motor_done = 1'b1;
    step();
    motor_done = 1'b0;
    chk("in_change", 32'(hopper_en), 32'd1);

    // Reset mid-CHANGE with two queued requests
    rst_n = 1'b0;
    step();
    chk("rst_mid", {26'b0, motor_en, hopper_en, busy, fault, ovf, 1'b0}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_idle", {29'b0, motor_en, hopper_en, busy}, 32'd0);
    end

    // Lone chg5 is not a request
    chg5 = 1'b1;
    step(); step();
    chg5 = 1'b0;
    chk("lone_chg5", 32'(busy), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      dispense    = ($urandom_range(0, 4) == 0);
      chg5        = $urandom_range(0, 1) == 1;
      motor_done  = ($urandom_range(0, 4) == 0);
      hopper_done = ($urandom_range(0, 3) == 0);
      fault_clr   = ($urandom_range(0, 5) == 0);
      step();
    end
    rst_n = 1'b1; dispense = 1'b0; fault_clr = 1'b0;
    step();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vend_fulfil_ctrl.md
Name: vend_fulfil_ctrl

Overview:
- Downstream end of the vending controller's dispense/chg5 pulse interface.
- Captures each one-cycle vend request (with or without 5-unit change) into a small request FIFO.
- Sequences the product motor and the change hopper through a level enable/done handshake, with a per-actuation timeout and a sticky fault.
- Sits between the vending FSM and the actuator drivers; all outputs are registered.

Parameters:
- DEPTH, 4: request FIFO entries; power of 2, minimum 2.
- TIMEOUT, 1000: maximum cycles an enable may stay high without its done before a fault; minimum 2.
- CNT_W, 16: width of vend_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- dispense  in  1  one-cycle vend request pulse from the vending FSM.
- chg5  in  1  qualifies dispense: 1 = return one 5-unit coin; ignored when dispense=0.
- motor_done  in  1  product motor completion, level.
- hopper_done  in  1  change hopper completion, level.
- fault_clr  in  1  clears fault and ovf; honoured only in FAULT state for the fault flag.
- motor_en  out  1  product motor enable.
- hopper_en  out  1  change hopper enable.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- fault  out  1  sticky actuation timeout.
- ovf  out  1  sticky: a request was dropped because the FIFO was full.
- vend_count  out  CNT_W  completed vends, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All outputs, the FIFO pointers/count and the timeout counter go to 0.
  - FSM goes to IDLE.
  - Reset mid-actuation drops the enable on the next edge and discards all queued requests.
- Push: dispense=1 at an edge writes entry {chg5}.
  - Accepted when count<DEPTH, or when count==DEPTH and a pop occurs on the same edge.
  - Otherwise the request is dropped and ovf is set.
  - A lone chg5 (dispense=0) is ignored.
- Pop: occurs on the IDLE->VEND transition; the head entry's chg bit is latched into chg_q.
- FSM states: IDLE, VEND, CHANGE, GAP, FAULT.
  - IDLE: FIFO non-empty -> VEND (pop).
  - VEND: motor_en=1. motor_done=1 -> CHANGE if chg_q, else GAP; vend_count increments on this edge.
  - CHANGE: hopper_en=1. hopper_done=1 -> GAP.
  - GAP: both enables 0 for exactly one cycle -> IDLE. Guarantees done de-assertion between actuations.
  - FAULT: both enables 0, fault=1. fault_clr=1 -> IDLE with fault cleared. The failed request is not retried; queued requests are kept and pushes continue.
- Timeout: counter clears on entry to VEND or CHANGE and increments each cycle in that state.
  - If the done input is not seen by the TIMEOUT-th cycle in the state -> FAULT.
  - done and expiry on the same cycle: done wins.
  - A motor timeout does not increment vend_count.
- Outputs are registered decodes of the state: motor_en is high exactly in the cycles the FSM is in VEND.
- Latency: dispense high in cycle n, FIFO empty, FSM IDLE -> motor_en high from cycle n+2.
- done inputs are ignored outside their own state; motor_done is never looked at in CHANGE.
- ovf is cleared by fault_clr in any state. If a drop and fault_clr occur on the same edge, set wins.
- busy = (state!=IDLE) | (count!=0).

Test Plan:
- Single vend, no change: dispense=1, chg5=0 in cycle 10; motor_done=1 in cycle 15 -> motor_en high cycles 12-15, hopper_en never high, vend_count=1, busy low from cycle 17.
- Vend with change: dispense=1, chg5=1; motor_done after 3 cycles, hopper_done after 2 cycles -> motor_en then hopper_en back-to-back, then 1 GAP cycle, vend_count=1.
- Overflow: 6 dispense pulses on consecutive cycles, DEPTH=4, motor_done held 0 -> the first is popped, the next 4 are queued, the 6th is dropped, ovf=1.
- Timeout: TIMEOUT=8, motor_done never asserts -> motor_en high 8 cycles, fault=1, vend_count unchanged. fault_clr -> next queued request starts.
- Reset mid-CHANGE: rst_n=0 while hopper_en=1 with 2 queued requests -> the next cycle has all outputs 0, busy=0, and no actuation follows reset release.
- Lone chg5=1 with dispense=0 -> no push, busy stays 0.
